// File: rtl/sdram_pkg.sv
// Shared SDRAM responder definitions: command codes, mode-register fields, bank state.
// Pure declarations; no timing or flow control of its own.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  localparam int MR_BL_LSB      = 0;
  localparam int MR_CL_LSB      = 4;
  localparam int MR_WSINGLE_BIT = 9;
  localparam int AP_BIT         = 10;

  typedef struct packed {
    logic        open;
    logic [12:0] row;
  } bank_t;

  function automatic logic [3:0] bl_decode(input logic [2:0] code);
    case (code)
      3'b000:  return 4'd1;
      3'b001:  return 4'd2;
      3'b010:  return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Next column of a sequential burst, wrapping inside the BL-aligned block.
  function automatic logic [12:0] wrap_col(input logic [12:0] col, input logic [3:0] bl);
    logic [12:0] mask;
    mask = {9'd0, bl - 4'd1};
    return (col & ~mask) | ((col + 13'd1) & mask);
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Backing store: 16-bit single-port RAM, per-byte write enables, 1-cycle registered read.
// Read data appears the cycle after the address is presented; no reset of contents.
module sdram_resp_mem #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem_q [2**AW];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we && be[0]) mem_q[addr][7:0]  <= wdata[7:0];
    if (we && be[1]) mem_q[addr][15:8] <= wdata[15:8];
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sdram_responder.sv
// SDRAM device model: decodes bus commands, serves CL-delayed read bursts and burst writes.
// Read beat i of a READ at edge T is driven in cycle T+CL+i; the bus has no backpressure.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int MEM_AW   = 16,
  parameter int COL_BITS = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sd_ncs,
  input  logic        sd_nras,
  input  logic        sd_ncas,
  input  logic        sd_nwe,
  input  logic [1:0]  sd_ba,
  input  logic [12:0] sd_a,
  input  logic        sd_dqml,
  input  logic        sd_dqmh,
  input  logic [15:0] sd_dq_in,
  output logic [15:0] sd_dq_out,
  output logic        sd_dq_oe,
  output logic        mode_valid,
  output logic [15:0] refresh_cnt,
  output logic [3:0]  err
);

  bank_t [3:0]             bank_q, bank_d;
  logic [3:0]              bl_q, bl_d;
  logic                    cl3_q, cl3_d;
  logic                    wsingle_q, wsingle_d;
  logic                    mode_valid_q, mode_valid_d;
  logic [15:0]             refresh_cnt_q, refresh_cnt_d;
  logic [3:0]              err_q, err_d;
  logic [3:0]              brst_left_q, brst_left_d;
  logic                    brst_wr_q, brst_wr_d;
  logic                    brst_ap_q, brst_ap_d;
  logic [1:0]              brst_ba_q, brst_ba_d;
  logic [12:0]             brst_row_q, brst_row_d;
  logic [12:0]             brst_col_q, brst_col_d;
  logic [2:0]              pipe_vld_q, pipe_vld_d;
  logic [2:0][MEM_AW-1:0]  pipe_addr_q, pipe_addr_d;
  logic                    oe_q, oe_d;

  cmd_e              cmd;
  logic              rw_ok;
  logic              iss_vld;
  logic [MEM_AW-1:0] iss_addr;
  logic              mem_we;
  logic [1:0]        mem_be;
  logic [MEM_AW-1:0] wr_addr;
  logic [MEM_AW-1:0] rd_addr;
  logic [MEM_AW-1:0] cmd_addr;
  logic [MEM_AW-1:0] brst_addr;
  logic [15:0]       mem_rdata;

  function automatic logic [MEM_AW-1:0] mk_addr(input logic [1:0] ba, input logic [12:0] row,
                                                input logic [COL_BITS-1:0] col);
    return MEM_AW'({ba, row, col});
  endfunction

  assign cmd_addr  = mk_addr(sd_ba, bank_q[sd_ba].row, sd_a[COL_BITS-1:0]);
  assign brst_addr = mk_addr(brst_ba_q, brst_row_q, brst_col_q[COL_BITS-1:0]);

  always_comb begin
    cmd           = sd_ncs ? CMD_NOP : cmd_e'({sd_nras, sd_ncas, sd_nwe});
    rw_ok         = ((cmd == CMD_RD) || (cmd == CMD_WR)) && bank_q[sd_ba].open;
    bank_d        = bank_q;
    bl_d          = bl_q;
    cl3_d         = cl3_q;
    wsingle_d     = wsingle_q;
    mode_valid_d  = mode_valid_q;
    refresh_cnt_d = refresh_cnt_q;
    err_d         = err_q;
    brst_left_d   = brst_left_q;
    brst_wr_d     = brst_wr_q;
    brst_ap_d     = brst_ap_q;
    brst_ba_d     = brst_ba_q;
    brst_row_d    = brst_row_q;
    brst_col_d    = brst_col_q;
    iss_vld       = 1'b0;
    iss_addr      = '0;
    mem_we        = 1'b0;
    mem_be        = 2'b00;
    wr_addr       = '0;

    // Continue the running burst unless a new accepted access replaces it.
    if (brst_left_q != 4'd0 && !rw_ok) begin
      if (brst_wr_q) begin
        mem_we  = 1'b1;
        mem_be  = ~{sd_dqmh, sd_dqml};
        wr_addr = brst_addr;
      end else begin
        iss_vld  = 1'b1;
        iss_addr = brst_addr;
      end
      brst_left_d = brst_left_q - 4'd1;
      brst_col_d  = wrap_col(brst_col_q, bl_q);
      if (brst_left_q == 4'd1 && brst_ap_q) bank_d[brst_ba_q].open = 1'b0;
    end

    case (cmd)
      CMD_LMR: begin
        bl_d         = bl_decode(sd_a[MR_BL_LSB +: 3]);
        cl3_d        = (sd_a[MR_CL_LSB +: 3] == 3'd3);
        wsingle_d    = sd_a[MR_WSINGLE_BIT];
        mode_valid_d = 1'b1;
      end
      CMD_REF: begin
        if (refresh_cnt_q != 16'hFFFF) refresh_cnt_d = refresh_cnt_q + 16'd1;
        if (bank_q[0].open || bank_q[1].open || bank_q[2].open || bank_q[3].open) err_d[3] = 1'b1;
      end
      CMD_PRE: begin
        if (sd_a[AP_BIT]) begin
          for (int b = 0; b < 4; b++) bank_d[b].open = 1'b0;
        end else begin
          bank_d[sd_ba].open = 1'b0;
        end
      end
      CMD_ACT: begin
        if (!mode_valid_q) err_d[2] = 1'b1;
        if (bank_q[sd_ba].open) err_d[1] = 1'b1;
        bank_d[sd_ba] = '{open: 1'b1, row: sd_a};
      end
      CMD_RD, CMD_WR: begin
        if (!mode_valid_q) err_d[2] = 1'b1;
        if (!rw_ok) begin
          err_d[0] = 1'b1;
        end else begin
          if (cmd == CMD_WR) begin
            mem_we  = 1'b1;
            mem_be  = ~{sd_dqmh, sd_dqml};
            wr_addr = cmd_addr;
          end else begin
            iss_vld  = 1'b1;
            iss_addr = cmd_addr;
          end
          brst_left_d = (cmd == CMD_WR && wsingle_q) ? 4'd0 : bl_q - 4'd1;
          brst_wr_d   = (cmd == CMD_WR);
          brst_ap_d   = sd_a[AP_BIT];
          brst_ba_d   = sd_ba;
          brst_row_d  = bank_q[sd_ba].row;
          brst_col_d  = wrap_col(13'(sd_a[COL_BITS-1:0]), bl_q);
          if (brst_left_d == 4'd0 && sd_a[AP_BIT]) bank_d[sd_ba].open = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Issued read beats age through a shift line; the CL tap feeds the RAM one cycle early.
  always_comb begin
    pipe_vld_d  = {pipe_vld_q[1:0], iss_vld};
    pipe_addr_d = {pipe_addr_q[1:0], iss_addr};
    oe_d        = cl3_q ? pipe_vld_q[2] : pipe_vld_q[1];
    rd_addr     = cl3_q ? pipe_addr_q[2] : pipe_addr_q[1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q        <= '0;
      bl_q          <= 4'd1;
      cl3_q         <= 1'b0;
      wsingle_q     <= 1'b0;
      mode_valid_q  <= 1'b0;
      refresh_cnt_q <= '0;
      err_q         <= '0;
      brst_left_q   <= '0;
      brst_wr_q     <= 1'b0;
      brst_ap_q     <= 1'b0;
      brst_ba_q     <= '0;
      brst_row_q    <= '0;
      brst_col_q    <= '0;
      pipe_vld_q    <= '0;
      pipe_addr_q   <= '0;
      oe_q          <= 1'b0;
    end else begin
      bank_q        <= bank_d;
      bl_q          <= bl_d;
      cl3_q         <= cl3_d;
      wsingle_q     <= wsingle_d;
      mode_valid_q  <= mode_valid_d;
      refresh_cnt_q <= refresh_cnt_d;
      err_q         <= err_d;
      brst_left_q   <= brst_left_d;
      brst_wr_q     <= brst_wr_d;
      brst_ap_q     <= brst_ap_d;
      brst_ba_q     <= brst_ba_d;
      brst_row_q    <= brst_row_d;
      brst_col_q    <= brst_col_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_addr_q   <= pipe_addr_d;
      oe_q          <= oe_d;
    end
  end

  // A write takes the single port; a read beat due the same cycle returns that word's old data.
  sdram_resp_mem #(.AW(MEM_AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (mem_we ? wr_addr : rd_addr),
    .wdata (sd_dq_in),
    .rdata (mem_rdata)
  );

  assign sd_dq_out   = oe_q ? mem_rdata : 16'h0000;
  assign sd_dq_oe    = oe_q;
  assign mode_valid  = mode_valid_q;
  assign refresh_cnt = refresh_cnt_q;
  assign err         = err_q;

endmodule

// File: doc/sdram_responder.md
SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 16, meaning the number of word-address bits of the internal backing store (2^MEM_AW x 16 bit).
REQ-002 SHALL have parameter COL_BITS, default 9, meaning the column address width taken from sd_a.
REQ-003 SHALL have port clk, input, 1 bit: the single clock. All SDRAM-side inputs are sampled on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports sd_ncs, sd_nras, sd_ncas, sd_nwe, inputs, 1 bit each: the command pins, active-low.
REQ-006 SHALL have port sd_ba, input, 2 bits: bank select.
REQ-007 SHALL have port sd_a, input, 13 bits: multiplexed row/column/mode address.
REQ-008 SHALL have ports sd_dqml and sd_dqmh, inputs, 1 bit each: write byte masks (1 = byte not written).
REQ-009 SHALL have port sd_dq_in, input, 16 bits: write data.
REQ-010 SHALL have port sd_dq_out, output, 16 bits: read data.
REQ-011 SHALL have port sd_dq_oe, output, 1 bit: high while sd_dq_out carries a valid read beat.
REQ-012 SHALL have port mode_valid, output, 1 bit: set once a LOAD_MODE command has been received.
REQ-013 SHALL have port refresh_cnt, output, 16 bits: count of AUTO_REFRESH commands received, saturating at 0xFFFF.
REQ-014 SHALL have port err, output, 4 bits: sticky protocol-error flags as defined in REQ-025.

Function
REQ-015 SHALL decode commands only when sd_ncs=0, using {nRAS,nCAS,nWE}: 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 AUTO_REFRESH, 000 LOAD_MODE; sd_ncs=1 SHALL be treated as NOP.
REQ-016 LOAD_MODE SHALL latch burst length from A[2:0] (000=1, 001=2, 010=4, 011=8; other codes = 8), CAS latency from A[6:4] (2 or 3; other codes = 2), and single-write mode from A[9]; it SHALL set mode_valid.
REQ-017 SHALL track per bank an open flag and a 13-bit row; ACTIVE opens the addressed bank with row = sd_a.
REQ-018 PRECHARGE SHALL close bank sd_ba, or all four banks when A[10]=1.
REQ-019 Word address SHALL be {ba, row, col} truncated to MEM_AW LSBs, where col = sd_a[COL_BITS-1:0].
REQ-020 READ at edge T SHALL drive burst beat i on sd_dq_out with sd_dq_oe=1 during cycle T+CL+i, for i = 0..BL-1.
REQ-021 Burst addressing SHALL be sequential, wrapping within the BL-aligned column block (start col 6, BL=4 -> cols 6,7,4,5).
REQ-022 WRITE SHALL store sd_dq_in into the addressed word in the same cycle, honouring DQM per byte. Single-write mode writes one beat. Otherwise BL beats are taken on consecutive cycles, each beat masked by that cycle's DQM.
REQ-023 A READ or WRITE issued while a burst is in progress SHALL terminate the old burst. Read beats already in the CL pipeline SHALL still be driven unless they collide with new read beats, in which case the new beats win.
REQ-024 READ/WRITE with A[10]=1 SHALL close the bank after its last beat is issued. PRECHARGE SHALL NOT truncate a burst in progress.
REQ-025 SHALL set the following sticky bits, each cleared only by reset; the offending command is still executed except where stated:
- err[0]: READ/WRITE to a closed bank; the access is ignored.
- err[1]: ACTIVE to an already open bank; the row is overwritten.
- err[2]: any command other than NOP, PRECHARGE, AUTO_REFRESH or LOAD_MODE while mode_valid=0.
- err[3]: AUTO_REFRESH while any bank is open.
REQ-026 sd_dq_out SHALL read 0 whenever sd_dq_oe=0.

Reset
REQ-027 While reset_n=0, all outputs SHALL be 0, all banks closed, the CL pipeline flushed, mode_valid=0, and the mode register set to BL=1, CL=2.
REQ-028 Reset asserted mid-burst SHALL abort the burst immediately; memory contents SHALL NOT be reset.

Structure
REQ-029 A shared package sdram_pkg SHALL hold the command encodings, the mode-field bit positions, and the bank-state record type.
REQ-030 Storage SHALL be the sub-module sdram_resp_mem: a 16-bit single-port RAM with byte enables and 1-cycle synchronous read. Read address SHALL be issued one cycle before the data is needed.

Verification
REQ-031 LOAD_MODE A=0x023 (BL8, CL2, burst write), ACTIVE bank1 row 0x55, 8-beat WRITE col 0 with data 0x1000..0x1007, then READ col 0 at edge T -> sd_dq_oe high T+2..T+9, data 0x1000..0x1007.
REQ-032 Mode CL3, BL4, single-write mode: write 0xAAAA with DQML=1, DQMH=0 over a word holding 0x1234, then READ col 6 -> first beat 0xAA34 at T+3, then cols 7,4,5.
REQ-033 READ at T followed by READ to another column at T+2 (CL2, BL8) -> beats 0,1 of the first burst, then the second burst from T+4.
REQ-034 READ to a closed bank -> err[0]=1 and sd_dq_oe stays 0. AUTO_REFRESH with bank 2 open -> err[3]=1 and refresh_cnt increments.
REQ-035 reset_n low at beat 3 of an 8-beat read -> sd_dq_oe=0 immediately. After reset: mode_valid=0 and memory data is retained.
